csr_regfile: RTL and testbench
==============================

// Module: csr_regfile
// PURPOSE
//  Machine-mode CSR register file; serves the CSR Unit through the csrrf side of csr_csru_if.
//  Holds M-mode CSR state, applies WARL masks on writes, returns read data one cycle after request.
//  Owns the 64-bit mcycle/minstret counters. Exports mtvec/mepc/MIE to the trap/fetch logic.
// PARAMETERS
//  HART_ID        0             value returned by mhartid
//  MISA_VALUE     32'h40000100  read-only misa value (RV32I)
//  RESET_MTVEC    32'h00000000  mtvec value after reset (bits [1:0] must be 0)
//  (XLEN taken from COMMON_PARAMS; XLEN=32 only)
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous reset, active-high
//  csru          io   -     csr_csru_if.csrrf: read_req/write_req in, read_res out
//  retire_valid  in   1     one instruction retired this cycle (minstret increment)
//  mtvec_o       out  XLEN  current mtvec
//  mepc_o        out  XLEN  current mepc
//  mie_global_o  out  1     mstatus.MIE
// BEHAVIOUR
//  Implemented CSRs: MSTATUS, MISA, MIE, MTVEC, MSCRATCH, MEPC, MCAUSE, MTVAL, MIP,
//   MHARTID, MCYCLE, MCYCLEH, MINSTRET, MINSTRETH (csr_name_e enumerators).
//  Reset (rst=1 at posedge): read_res.valid=0, read_res.data=0; mstatus=0x0000_1800;
//   mtvec=RESET_MTVEC; mie/mscratch/mepc/mcause/mtval=0; mcycle=minstret=64'h0.
//  Read: read_req.valid at cycle N -> read_res.valid=1 at N+1, data=value at cycle N;
//   no req at N -> read_res.valid=0 at N+1, data holds last value. Fixed 1-cycle latency, no stall.
//  Write: write_req.valid at cycle N -> CSR updated at posedge ending N (visible to reads issued N+1).
//  Same-cycle read+write of same CSR: read returns OLD value (CSRRW semantics).
//  WARL masks on write: mstatus only MIE[3], MPIE[7] writable, MPP[12:11] reads 2'b11 always;
//   mtvec[1:0] forced 0 (direct mode); mepc[1:0] forced 0; mcause bits [30:4] forced 0.
//  Read-only: MISA, MHARTID, MIP (reads 0); writes to them silently ignored.
//  Unknown/unimplemented csr_name: read -> valid=1, data=0; write ignored (illegal-CSR trap is CSRU's job).
//  Counters: mcycle +1 every cycle not in reset; minstret +1 when retire_valid=1.
//   64-bit wrap: 64'hFFFF_FFFF_FFFF_FFFF -> 0. MCYCLE/MINSTRET access bits[31:0], *H bits[63:32].
//   Software write to a half in cycle N: written half takes write data, other half keeps
//   its pre-increment value; no increment that cycle (write wins over increment).
//   Carry from low to high half only via normal increment.
//  rst mid-operation: pending read response dropped (valid=0 next cycle), all state to reset values.
//  Outputs mtvec_o/mepc_o/mie_global_o are direct register outputs (0-cycle from state).
// CONFIGURATION
//  CSR_COUNTERS_EN defined: mcycle/minstret(+H) implemented as above.
//  Not defined: no counter flops; MCYCLE/MCYCLEH/MINSTRET/MINSTRETH read 0, writes ignored,
//   retire_valid unused. All other behaviour identical.
// TESTING
//  T1 reset: assert rst 2 cycles -> read MSTATUS gives 0x1800 at N+1, read_res.valid low during/after rst.
//  T2 WARL: write MTVEC=0x8000_0003 then read -> 0x8000_0000; write MSTATUS=0xFFFF_FFFF -> read 0x0000_1888.
//  T3 same-cycle: MSCRATCH=0x11, then read+write(0x22) same cycle -> read 0x11; next read 0x22.
//  T4 wrap (CSR_COUNTERS_EN): write MCYCLEH=0xFFFF_FFFF, MCYCLE=0xFFFF_FFFE; 2 idle cycles -> MCYCLE=0, MCYCLEH=0.
//  T5 minstret: retire_valid high 5 cycles from 0 -> MINSTRET reads 5; write MINSTRET=7 with retire_valid=1 -> reads 7.
//  T6 unknown/RO: read unimplemented name -> valid=1,data=0; write MHARTID=5 -> reads HART_ID.

Source files
------------

// File: rtl/csr_regfile_if.sv
// CSR register file shared types and the CSR Unit <-> register file interface.
// csr_csru_if.csrrf is the register-file side; master/slave give generic roles.
package csr_pkg;
    localparam int unsigned XLEN = 32;

    typedef enum logic [11:0] {
        MSTATUS   = 12'h300,
        MISA      = 12'h301,
        MIE       = 12'h304,
        MTVEC     = 12'h305,
        MSCRATCH  = 12'h340,
        MEPC      = 12'h341,
        MCAUSE    = 12'h342,
        MTVAL     = 12'h343,
        MIP       = 12'h344,
        MCYCLE    = 12'hB00,
        MINSTRET  = 12'hB02,
        MCYCLEH   = 12'hB80,
        MINSTRETH = 12'hB82,
        MHARTID   = 12'hF14
    } csr_name_e;

    typedef struct packed {
        logic      valid;
        csr_name_e name;
    } csr_read_req_t;

    typedef struct packed {
        logic            valid;
        csr_name_e       name;
        logic [XLEN-1:0] data;
    } csr_write_req_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] data;
    } csr_read_res_t;
endpackage

interface csr_csru_if;
    import csr_pkg::*;

    csr_read_req_t  read_req;
    csr_write_req_t write_req;
    csr_read_res_t  read_res;

    modport master (output read_req, output write_req, input read_res);
    modport slave  (input read_req, input write_req, output read_res);
    modport csrrf  (input read_req, input write_req, output read_res);
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with WARL write masks and 1-cycle read latency.
// Optional macro CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters.
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [XLEN-1:0] HART_ID     = 32'd0,
    parameter logic [XLEN-1:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    csr_csru_if.csrrf       csru,
    input  logic            retire_valid,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_global_o
);

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wdata;

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
    assign wdata      = csru.write_req.data;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
`else
    logic unused_retire;
    assign unused_retire = retire_valid;
`endif

    always_comb begin
        rdata = '0;
        unique case (csru.read_req.name)
            MSTATUS:   rdata = mstatus_rd;
            MISA:      rdata = MISA_VALUE;
            MIE:       rdata = mie_q;
            MTVEC:     rdata = mtvec_q;
            MSCRATCH:  rdata = mscratch_q;
            MEPC:      rdata = mepc_q;
            MCAUSE:    rdata = mcause_q;
            MTVAL:     rdata = mtval_q;
            MHARTID:   rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            MCYCLE:    rdata = mcycle_q[31:0];
            MCYCLEH:   rdata = mcycle_q[63:32];
            MINSTRET:  rdata = minstret_q[31:0];
            MINSTRETH: rdata = minstret_q[63:32];
`endif
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csru.read_res.valid <= 1'b0;
            csru.read_res.data  <= '0;
        end else if (csru.read_req.valid) begin
            csru.read_res.valid <= 1'b1;
            csru.read_res.data  <= rdata;
        end else begin
            csru.read_res.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= RESET_MTVEC;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
        end else if (csru.write_req.valid) begin
            case (csru.write_req.name)
                MSTATUS: begin
                    mstatus_mie  <= wdata[3];
                    mstatus_mpie <= wdata[7];
                end
                MIE:      mie_q      <= wdata;
                MTVEC:    mtvec_q    <= {wdata[31:2], 2'b00};
                MSCRATCH: mscratch_q <= wdata;
                MEPC:     mepc_q     <= {wdata[31:2], 2'b00};
                MCAUSE:   mcause_q   <= {wdata[31], 27'd0, wdata[3:0]};
                MTVAL:    mtval_q    <= wdata;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // A software write to either half replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_q + 64'd1;
            minstret_q <= minstret_q + {63'd0, retire_valid};
            if (csru.write_req.valid) begin
                case (csru.write_req.name)
                    MCYCLE:    mcycle_q   <= {mcycle_q[63:32], wdata};
                    MCYCLEH:   mcycle_q   <= {wdata, mcycle_q[31:0]};
                    MINSTRET:  minstret_q <= {minstret_q[63:32], wdata};
                    MINSTRETH: minstret_q <= {wdata, minstret_q[31:0]};
                    default: ;
                endcase
            end
        end
    end
`endif

    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    assign mie_global_o = mstatus_mie;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile: vector table plus reset/counter sequences.
module tb_csr_regfile;
    import csr_pkg::*;

    localparam logic [31:0] TB_HART_ID = 32'd3;
    localparam logic [31:0] TB_MTVEC   = 32'h0000_0100;
    localparam logic [11:0] UNKNOWN    = 12'h7C0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic retire_valid = 1'b0;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_global_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    csr_csru_if bus ();

    csr_regfile #(
        .HART_ID     (TB_HART_ID),
        .MISA_VALUE  (32'h4000_0100),
        .RESET_MTVEC (TB_MTVEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csru         (bus.csrrf),
        .retire_valid (retire_valid),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mie_global_o (mie_global_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_v;
        logic [11:0] wr_name;
        logic [31:0] wr_data;
        logic        rd_v;
        logic [11:0] rd_name;
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_mie;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic wv, input logic [11:0] wn, input logic [31:0] wd,
                                input logic rv, input logic [11:0] rn,
                                input logic ev, input logic [31:0] ed, input logic em);
        vec_t v;
        v.wr_v = wv; v.wr_name = wn; v.wr_data = wd;
        v.rd_v = rv; v.rd_name = rn;
        v.exp_v = ev; v.exp_d = ed; v.exp_mie = em;
        return v;
    endfunction

    task automatic drive(input logic wv, input logic [11:0] wn, input logic [31:0] wd,
                         input logic rv, input logic [11:0] rn, input logic ret);
        bus.write_req.valid = wv;
        bus.write_req.name  = csr_name_e'(wn);
        bus.write_req.data  = wd;
        bus.read_req.valid  = rv;
        bus.read_req.name   = csr_name_e'(rn);
        retire_valid        = ret;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic read_check(input string nm, input logic [11:0] rn, input logic ret,
                              input logic [31:0] exp);
        drive(1'b0, 12'h0, 32'h0, 1'b1, rn, ret);
        step();
        check({nm, "_valid"}, {31'd0, bus.read_res.valid}, 32'd1);
        check(nm, bus.read_res.data, exp);
    endtask

    initial begin
        vecs[0]  = mk(1, MTVEC,    32'h8000_0003, 0, 12'h0,    0, 32'h0000_1800, 0);
        vecs[1]  = mk(0, 12'h0,    32'h0,         1, MTVEC,    1, 32'h8000_0000, 0);
        vecs[2]  = mk(1, MSTATUS,  32'hFFFF_FFFF, 0, 12'h0,    0, 32'h8000_0000, 1);
        vecs[3]  = mk(0, 12'h0,    32'h0,         1, MSTATUS,  1, 32'h0000_1888, 1);
        vecs[4]  = mk(1, MSCRATCH, 32'h0000_0011, 0, 12'h0,    0, 32'h0000_1888, 1);
        vecs[5]  = mk(1, MSCRATCH, 32'h0000_0022, 1, MSCRATCH, 1, 32'h0000_0011, 1);
        vecs[6]  = mk(0, 12'h0,    32'h0,         1, MSCRATCH, 1, 32'h0000_0022, 1);
        vecs[7]  = mk(0, 12'h0,    32'h0,         1, UNKNOWN,  1, 32'h0000_0000, 1);
        vecs[8]  = mk(1, MHARTID,  32'h0000_0005, 0, 12'h0,    0, 32'h0000_0000, 1);
        vecs[9]  = mk(0, 12'h0,    32'h0,         1, MHARTID,  1, TB_HART_ID,    1);
        vecs[10] = mk(1, MEPC,     32'h1234_5677, 0, 12'h0,    0, TB_HART_ID,    1);
        vecs[11] = mk(0, 12'h0,    32'h0,         1, MEPC,     1, 32'h1234_5674, 1);
        vecs[12] = mk(1, MCAUSE,   32'hFFFF_FFFF, 0, 12'h0,    0, 32'h1234_5674, 1);
        vecs[13] = mk(0, 12'h0,    32'h0,         1, MCAUSE,   1, 32'h8000_000F, 1);
        vecs[14] = mk(1, MISA,     32'h0000_0000, 1, MISA,     1, 32'h4000_0100, 1);
        vecs[15] = mk(0, 12'h0,    32'h0,         1, MISA,     1, 32'h4000_0100, 1);
        vecs[16] = mk(1, MIP,      32'hFFFF_FFFF, 1, MIP,      1, 32'h0000_0000, 1);
        vecs[17] = mk(1, MTVAL,    32'hDEAD_BEEF, 0, 12'h0,    0, 32'h0000_0000, 1);
        vecs[18] = mk(0, 12'h0,    32'h0,         1, MTVAL,    1, 32'hDEAD_BEEF, 1);
        vecs[19] = mk(1, UNKNOWN,  32'h0000_0055, 1, MSTATUS,  1, 32'h0000_1888, 1);
        vecs[20] = mk(1, MIE,      32'h0000_0888, 0, 12'h0,    0, 32'h0000_1888, 1);
        vecs[21] = mk(0, 12'h0,    32'h0,         1, MIE,      1, 32'h0000_0888, 1);
        vecs[22] = mk(1, MSTATUS,  32'h0000_0000, 1, MSTATUS,  1, 32'h0000_1888, 0);
        vecs[23] = mk(0, 12'h0,    32'h0,         1, MSTATUS,  1, 32'h0000_1800, 0);

        // Reset held two cycles with a read pending: no response may escape.
        rst = 1'b1;
        drive(1'b0, 12'h0, 32'h0, 1'b1, MSTATUS, 1'b0);
        step();
        check("rst1_valid", {31'd0, bus.read_res.valid}, 32'd0);
        step();
        check("rst2_valid", {31'd0, bus.read_res.valid}, 32'd0);
        check("rst2_data", bus.read_res.data, 32'd0);
        check("rst_mtvec_o", mtvec_o, TB_MTVEC);
        check("rst_mie_o", {31'd0, mie_global_o}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
        step();
        check("post_rst_valid", {31'd0, bus.read_res.valid}, 32'd0);
        read_check("rst_mstatus", MSTATUS, 1'b0, 32'h0000_1800);

        foreach (vecs[i]) begin
            drive(vecs[i].wr_v, vecs[i].wr_name, vecs[i].wr_data,
                  vecs[i].rd_v, vecs[i].rd_name, 1'b0);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, bus.read_res.valid}, {31'd0, vecs[i].exp_v});
            check($sformatf("vec%0d_data", i), bus.read_res.data, vecs[i].exp_d);
            check($sformatf("vec%0d_mie", i), {31'd0, mie_global_o}, {31'd0, vecs[i].exp_mie});
        end
        check("mtvec_o", mtvec_o, 32'h8000_0000);
        check("mepc_o", mepc_o, 32'h1234_5674);

        // Reset mid-operation drops the pending read and restores reset state.
        rst = 1'b1;
        drive(1'b0, 12'h0, 32'h0, 1'b1, MSCRATCH, 1'b0);
        step();
        check("midrst_valid", {31'd0, bus.read_res.valid}, 32'd0);
        check("midrst_data", bus.read_res.data, 32'd0);
        check("midrst_mtvec_o", mtvec_o, TB_MTVEC);
        check("midrst_mepc_o", mepc_o, 32'd0);
        rst = 1'b0;
        read_check("midrst_mscratch", MSCRATCH, 1'b0, 32'd0);
        read_check("midrst_mtvec", MTVEC, 1'b0, TB_MTVEC);

        rst = 1'b1;
        drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b0);
        step();
        rst = 1'b0;
`ifdef CSR_COUNTERS_EN
        read_check("mcycle_start", MCYCLE, 1'b1, 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 12'h0, 32'h0, 1'b0, 12'h0, 1'b1);
            step();
        end
        read_check("minstret_5", MINSTRET, 1'b0, 32'd5);
        drive(1'b1, MINSTRET, 32'd7, 1'b1, MINSTRETH, 1'b1);
        step();
        check("minstreth", bus.read_res.data, 32'd0);
        read_check("minstret_wr", MINSTRET, 1'b0, 32'd7);

        drive(1'b1, MCYCLEH, 32'hFFFF_FFFF, 1'b0, 12'h0, 1'b0);
        step();
        drive(1'b1, MCYCLE, 32'hFFFF_FFFE, 1'b0, 12'h0, 1'b0);
        step();
        read_check("wrap_lo_fe", MCYCLE, 1'b0, 32'hFFFF_FFFE);
        read_check("wrap_hi_ff", MCYCLEH, 1'b0, 32'hFFFF_FFFF);
        read_check("wrap_lo_0", MCYCLE, 1'b0, 32'd0);
        read_check("wrap_hi_0", MCYCLEH, 1'b0, 32'd0);
`else
        drive(1'b1, MCYCLE, 32'd5, 1'b0, 12'h0, 1'b1);
        step();
        read_check("nocnt_mcycle", MCYCLE, 1'b1, 32'd0);
        drive(1'b1, MINSTRET, 32'd7, 1'b0, 12'h0, 1'b1);
        step();
        read_check("nocnt_minstret", MINSTRET, 1'b1, 32'd0);
        read_check("nocnt_mcycleh", MCYCLEH, 1'b0, 32'd0);
        read_check("nocnt_minstreth", MINSTRETH, 1'b0, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
